// File: rtl/uart_pkg.sv
`default_nettype none
// ============================================================================
// Module  : uart_pkg
// Brief   : Shared types and constants for the UART transmit serializer.
// Revision: 1.0
// ============================================================================
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } uart_state_t;

    localparam int unsigned DEF_CLK_FREQ = 100_000_000;
    localparam int unsigned DEF_BAUD     = 115_200;
    localparam logic        LINE_IDLE    = 1'b1;

endpackage
`default_nettype wire

// File: rtl/uart_tx_serializer_if.sv
`default_nettype none
// ============================================================================
// Module  : uart_tx_serializer_if
// Brief   : Byte handshake between the print formatter and the serializer.
// Revision: 1.0
// ============================================================================
interface uart_tx_serializer_if;

    logic [7:0] d_tx;
    logic       vld_tx;
    logic       rdy_tx;

    modport master (output d_tx, output vld_tx, input  rdy_tx);
    modport slave  (input  d_tx, input  vld_tx, output rdy_tx);

endinterface
`default_nettype wire

// File: rtl/uart_baud_tick.sv
`default_nettype none
// ============================================================================
// Module  : uart_baud_tick
// Brief   : DIV-cycle bit timer; o_tick marks the last cycle of a bit period.
// Revision: 1.0
// ============================================================================
module uart_baud_tick #(
    parameter int unsigned DIV = 16
) (
    input  wire  clk,
    input  wire  rstn,
    input  wire  i_restart,
    output logic o_tick
);

    localparam int unsigned           c_cnt_w = $clog2(DIV);
    localparam logic [c_cnt_w-1:0]    c_last  = c_cnt_w'(DIV - 1);

    logic [c_cnt_w-1:0] r_cnt;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_cnt <= '0;
        end else if (i_restart || o_tick) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + c_cnt_w'(1);
        end
    end

    assign o_tick = (r_cnt == c_last);

endmodule
`default_nettype wire

// File: rtl/uart_tx_serializer.sv
`default_nettype none
// ============================================================================
// Module  : uart_tx_serializer
// Brief   : 8N1 UART transmitter with a one-byte holding buffer.
//           Define UART_TX_PARITY_EN to insert an even-parity bit (8E1).
// Revision: 1.0
// ============================================================================
module uart_tx_serializer
    import uart_pkg::*;
#(
    parameter int unsigned CLK_FREQ = DEF_CLK_FREQ,
    parameter int unsigned BAUD     = DEF_BAUD
) (
    input  wire                        clk,
    input  wire                        rstn,
    uart_tx_serializer_if.slave        tx_if,
    output logic                       txd,
    output logic                       busy
);

    localparam int unsigned DIV = CLK_FREQ / BAUD;

    uart_state_t r_state, w_state_next;
    logic [7:0]  r_shift, w_shift_next;
    logic [2:0]  r_bit_cnt, w_bit_next;
    logic [7:0]  r_hold;
    logic        r_hold_full, w_hold_full_next;
    logic        r_rdy;
    logic        r_txd, w_txd_next;
    logic        w_tick, w_load, w_accept;
`ifdef UART_TX_PARITY_EN
    logic        r_parity, w_parity_next;
`endif

    // Timer is held at zero while idle so START always gets a full bit period
    uart_baud_tick #(.DIV(DIV)) u_baud_tick (
        .clk       (clk),
        .rstn      (rstn),
        .i_restart (r_state == IDLE),
        .o_tick    (w_tick)
    );

    always_comb begin
        w_accept         = tx_if.vld_tx && r_rdy;
        w_load           = r_hold_full && ((r_state == IDLE) || ((r_state == STOP) && w_tick));
        w_hold_full_next = w_accept ? 1'b1 : (w_load ? 1'b0 : r_hold_full);
        w_state_next     = r_state;
        w_shift_next     = r_shift;
        w_bit_next       = r_bit_cnt;
`ifdef UART_TX_PARITY_EN
        w_parity_next    = r_parity;
`endif
        if (w_load) begin
            w_shift_next  = r_hold;
            w_bit_next    = 3'd0;
`ifdef UART_TX_PARITY_EN
            w_parity_next = ^r_hold;
`endif
        end

        case (r_state)
            IDLE:  if (w_load) w_state_next = START;
            START: if (w_tick) w_state_next = DATA;
            DATA: begin
                if (w_tick) begin
                    if (r_bit_cnt == 3'd7) begin
`ifdef UART_TX_PARITY_EN
                        w_state_next = PARITY;
`else
                        w_state_next = STOP;
`endif
                    end else begin
                        w_shift_next = {1'b0, r_shift[7:1]};
                        w_bit_next   = r_bit_cnt + 3'd1;
                    end
                end
            end
`ifdef UART_TX_PARITY_EN
            PARITY: if (w_tick) w_state_next = STOP;
`endif
            STOP:  if (w_tick) w_state_next = w_load ? START : IDLE;
            default: w_state_next = IDLE;
        endcase

        // Line level is computed from the next state so the pin changes on the transition edge
        case (w_state_next)
            START:   w_txd_next = 1'b0;
            DATA:    w_txd_next = w_shift_next[0];
`ifdef UART_TX_PARITY_EN
            PARITY:  w_txd_next = w_parity_next;
`endif
            default: w_txd_next = LINE_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state     <= IDLE;
            r_shift     <= '0;
            r_bit_cnt   <= '0;
            r_hold      <= '0;
            r_hold_full <= 1'b0;
            r_rdy       <= 1'b1;
            r_txd       <= LINE_IDLE;
`ifdef UART_TX_PARITY_EN
            r_parity    <= 1'b0;
`endif
        end else begin
            r_state     <= w_state_next;
            r_shift     <= w_shift_next;
            r_bit_cnt   <= w_bit_next;
            r_hold_full <= w_hold_full_next;
            r_rdy       <= !w_hold_full_next;
            r_txd       <= w_txd_next;
`ifdef UART_TX_PARITY_EN
            r_parity    <= w_parity_next;
`endif
            if (w_accept) begin
                r_hold <= tx_if.d_tx;
            end
        end
    end

    assign tx_if.rdy_tx = r_rdy;
    assign txd          = r_txd;
    assign busy         = (r_state != IDLE) || r_hold_full;

endmodule
`default_nettype wire

// File: doc/uart_tx_serializer.md
Name: uart_tx_serializer

Overview:
Downstream stage of the hex/byte print formatter. Consumes bytes over the d_tx/vld_tx/rdy_tx handshake and serialises them onto the board UART line.
- Frame format: 8N1, LSB first.
- One-byte holding buffer in front of the shift register, so the formatter can hand over the next character while the current one is still on the wire.
- Output txd drives the top-level UART pin directly.

Parameters:
CLK_FREQ, 100000000, system clock frequency in Hz
BAUD, 115200, line rate in bit/s; localparam DIV = CLK_FREQ/BAUD (integer division, must be >= 2)

Ports:
clk  input  1  system clock, rising edge
rstn  input  1  asynchronous active-low reset
d_tx  input  8  byte to send, sampled when vld_tx && rdy_tx
vld_tx  input  1  upstream byte valid
rdy_tx  output  1  holding buffer empty, byte can be accepted
txd  output  1  serial line, idle high
busy  output  1  high while a frame is on the line or the holding buffer is full

Behaviour:
- Clock and reset: clk rising edge. rstn asynchronous, active-low; it clears all state.
- Reset values: txd=1, rdy_tx=1, busy=0, holding buffer empty, FSM=IDLE, bit counter=0, baud counter=0.
- Handshake:
  - Transfer occurs at a rising edge where vld_tx=1 and rdy_tx=1; d_tx is copied into the holding register.
  - rdy_tx is registered and equals !hold_full.
  - vld_tx with rdy_tx=0 is ignored; the upstream must keep d_tx/vld_tx until it sees rdy_tx=1.
- Holding-to-shifter load: when hold_full=1 and the FSM is IDLE (or is at the last cycle of STOP), the byte moves to the shifter on that edge and hold_full clears.
  - If a new transfer lands on the same edge, hold_full stays 1 with the new byte.
- FSM states:
  - IDLE: txd=1. Goes to START on load.
  - START: txd=0 for DIV cycles, then DATA.
  - DATA: txd=shift[0]. After every DIV cycles, shift right and increment the bit counter. After bit 7, go to STOP (or PARITY if enabled).
  - STOP: txd=1 for DIV cycles. Then START if a load occurs, otherwise IDLE.
- Baud counter: counts 0..DIV-1 and resets to 0 on every state entry. A bit ends when count==DIV-1.
- Frame timing:
  - Frame = 10*DIV cycles, or 11*DIV cycles with parity.
  - Back-to-back frames have no idle gap.
  - Latency from the accept edge to the txd falling edge is 1 clock when the shifter is idle.
- txd is driven from a register (glitch-free).
- busy = (state != IDLE) || hold_full.
- Boundary cases:
  - DIV not an integer ratio: truncated; the rate error is accepted.
  - Reset mid-frame: txd returns to 1 immediately; the partial frame and the held byte are discarded.
  - vld_tx held high continuously: one byte is accepted per rdy_tx window; no duplication.

Optional Feature:
Macro UART_TX_PARITY_EN.
- Defined: a PARITY state is inserted between DATA and STOP. It drives the even-parity bit (XOR of the 8 data bits) for DIV cycles. Frame = 11*DIV cycles.
- Undefined: no PARITY state; 8N1 framing exactly as above.

Decomposition:
- Shared package uart_pkg:
  - state enum (IDLE, START, DATA, PARITY, STOP)
  - default CLK_FREQ/BAUD constants
  - LINE_IDLE=1'b1
- One sub-module: uart_baud_tick. It is a DIV-cycle counter with a sync restart input and a tick output; the FSM uses the tick as its bit-end strobe.

Test Plan:
- Setup: CLK_FREQ=16, BAUD=1 (DIV=16), parity off.
- Reset: txd=1, rdy_tx=1, busy=0 during reset and after release.
- Single byte: send 0x55 -> txd low 1 clk after accept; then bits 0,1,0,1,0,1,0,1,0,1 at 16 clk each; 160 clk total, then IDLE with busy=0.
- Back-to-back: send 0x41 then 0x0D, second presented while the first is shifting.
  - rdy_tx=0 until the first frame's STOP ends.
  - The second START follows immediately (no gap).
  - 320 clk total.
- Stall/ignore: vld_tx=1 with d_tx=0xAA while rdy_tx=0 -> not captured. Byte is accepted exactly once when rdy_tx returns; only one 0xAA frame appears.
- Reset mid-frame: assert rstn=0 during DATA bit 3 -> txd=1 asynchronously; after release no further frame; rdy_tx=1.
- Parity build: send 0x07 -> parity bit 1; send 0x55 -> parity bit 0; frame 176 clk.
